pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage register for inter-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB class).
- Adds valid/ready handshake, a 2-entry skid buffer for registered backpressure, synchronous flush (kill), bubble forcing of control fields, and asynchronous active-low reset.
- One instance sits between two pipeline stages. Control and data payloads are split so that bubbles zero only what must be zeroed.

Parameters:
- CTRL_W, 8, width of control payload (RegWr, MemWr, MemRd, WBdata, ...); forced to zero on any bubble.
- DATA_W, 96, width of data payload (operands, NPC, Rd, ...); passed through unmodified.
- DATA_CLR, 1, 1 = data registers cleared to zero on flush; 0 = data registers hold their value on flush.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all buffered entries (branch/jump squash)
- in_valid  input  1  upstream stage presents an entry
- in_ready  output  1  buffer can accept; registered, equals NOT skid_valid
- in_ctrl  input  CTRL_W  upstream control payload
- in_data  input  DATA_W  upstream data payload
- out_valid  output  1  main entry valid
- out_ready  input  1  downstream stage consumes (0 = stall)
- out_ctrl  output  CTRL_W  main control payload, gated to 0 when out_valid=0
- out_data  output  DATA_W  main data payload register
- occupancy  output  2  number of valid entries (0..2)

Behaviour:
- Storage: main register (valid, ctrl, data) drives the outputs; skid register (valid, ctrl, data) holds one entry.
- Transfer rules: input transfer = in_valid AND in_ready. Output transfer = out_valid AND out_ready.
- Reset (rst_n=0, asynchronous): both valids=0, all ctrl/data registers=0.
  - Outputs during reset: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- Priority order: rst_n > flush > handshake.
- Flush (sampled at clk edge):
  - Both valids <= 0 and all ctrl registers <= 0.
  - Data registers <= 0 if DATA_CLR=1; otherwise they hold.
  - Any same-cycle input transfer is discarded.
  - Next cycle: in_ready=1, occupancy=0.
- Main register load condition: main empty OR output transfer.
  - Source is skid if skid_valid=1; else input if an input transfer occurs; else main_valid <= 0 (ctrl/data registers hold, out_ctrl gated to 0).
- Skid load condition: input transfer AND main_valid=1 AND out_ready=0 → skid captures the input, skid_valid <= 1.
- Skid drain: skid_valid <= 0 when the main register loads from skid.
  - If an input transfer also occurs that cycle, it would need main → impossible, since in_ready=0 whenever skid_valid=1.
- Latency: 1 cycle from input transfer to out_valid when empty. Sustained throughput 1 entry/cycle with out_ready=1.
- Stall (out_ready=0): main holds exactly. First incoming entry goes to skid, then in_ready drops on the next cycle.
  - No entry is ever lost or duplicated; ordering is FIFO.
- Bubble: out_ctrl = main_valid ? main_ctrl : 0, so downstream sees all-zero control (NOP) whenever there is no valid entry.
- Occupancy = main_valid + skid_valid. Value 2 implies in_ready=0.
- Invariant: skid_valid=1 implies main_valid=1.
- Reset asserted mid-transfer: all state cleared immediately regardless of clk. The first edge after rst_n rises behaves as from empty.
- in_ctrl/in_data are don't-care when in_valid=0 and must not alter state.

Test Plan:
- Reset: hold rst_n=0, toggle clk with in_valid=1 → out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0. Deassert rst_n mid-cycle → no spurious load before the next edge.
- Streaming: out_ready=1, present ctrl=8'h11/data=96'h1, then 8'h22/96'h2, then 8'h33/96'h3 on consecutive cycles → each appears on the outputs one cycle later in order, occupancy stays 1, in_ready stays 1.
- Backpressure/skid: with A in main, drop out_ready and send B, then C → B captured in skid, occupancy=2, in_ready=0, C held upstream. Raise out_ready → A, B, C delivered in order with no loss or duplication.
- Flush when full: occupancy=2, assert flush with in_valid=1 (D) → next cycle occupancy=0, out_valid=0, out_ctrl=0, D discarded. With DATA_CLR=1, out_data=0.
- Bubble gating: send one entry with ctrl=8'hFF, out_ready=1, then in_valid=0 → out_ctrl=0 and out_valid=0 one cycle after consumption, while out_data retains its last value.
- Simultaneous drain+fill: occupancy=1, out_ready=1, in_valid=1 every cycle for 10 cycles → occupancy stays 1, skid_valid never set.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake and a one-entry skid buffer.
// Control payload is zeroed on every bubble; data payload passes through untouched.
module pipe_stage_buf #(
    parameter int CTRL_W   = 8,
    parameter int DATA_W   = 96,
    parameter bit DATA_CLR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_vld_p1;
    logic [CTRL_W-1:0] main_ctrl_p1;
    logic [DATA_W-1:0] main_data_p1;
    logic              skid_vld_p1;
    logic [CTRL_W-1:0] skid_ctrl_p1;
    logic [DATA_W-1:0] skid_data_p1;

    logic in_xfer;
    logic main_load;
    logic skid_load;

    // in_ready depends only on skid state, so it is a registered signal
    assign in_ready  = ~skid_vld_p1;
    assign in_xfer   = in_valid & in_ready;
    assign main_load = ~main_vld_p1 | out_ready;
    assign skid_load = in_xfer & main_vld_p1 & ~out_ready;

    // ---- input -> main / skid registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_p1  <= 1'b0;
            main_ctrl_p1 <= '0;
            main_data_p1 <= '0;
            skid_vld_p1  <= 1'b0;
            skid_ctrl_p1 <= '0;
            skid_data_p1 <= '0;
        end else if (flush) begin
            main_vld_p1  <= 1'b0;
            main_ctrl_p1 <= '0;
            skid_vld_p1  <= 1'b0;
            skid_ctrl_p1 <= '0;
            if (DATA_CLR) begin
                main_data_p1 <= '0;
                skid_data_p1 <= '0;
            end
        end else begin
            if (main_load) begin
                if (skid_vld_p1) begin
                    main_vld_p1  <= 1'b1;
                    main_ctrl_p1 <= skid_ctrl_p1;
                    main_data_p1 <= skid_data_p1;
                    skid_vld_p1  <= 1'b0;
                end else if (in_xfer) begin
                    main_vld_p1  <= 1'b1;
                    main_ctrl_p1 <= in_ctrl;
                    main_data_p1 <= in_data;
                end else begin
                    // payload registers hold; the output gate hides stale control
                    main_vld_p1 <= 1'b0;
                end
            end
            // a skid load implies main is stalled, so it never collides with a drain
            if (skid_load) begin
                skid_vld_p1  <= 1'b1;
                skid_ctrl_p1 <= in_ctrl;
                skid_data_p1 <= in_data;
            end
        end
    end

    // ---- main register -> downstream ----
    assign out_valid = main_vld_p1;
    assign out_ctrl  = main_vld_p1 ? main_ctrl_p1 : '0;
    assign out_data  = main_data_p1;
    assign occupancy = {1'b0, main_vld_p1} + {1'b0, skid_vld_p1};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: vector table plus reset, drain+fill and async-reset sequences.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_ctrl = '0;
    logic [95:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_ctrl;
    logic [95:0] out_data;
    logic [1:0]  occupancy;

    int nvec = 0;
    int nerr = 0;

    pipe_stage_buf #(.CTRL_W(8), .DATA_W(96), .DATA_CLR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        flush;
        logic        vld;
        logic [7:0]  ctrl;
        logic [95:0] data;
        logic        rdy;
        logic        e_ov;
        logic [7:0]  e_ctrl;
        logic [95:0] e_data;
        logic        e_ir;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic ov, input logic [7:0] c,
                         input logic [95:0] d, input logic ir, input logic [1:0] occ);
        nvec++;
        if (out_valid !== ov || out_ctrl !== c || out_data !== d ||
            in_ready !== ir || occupancy !== occ) begin
            nerr++;
            $display("FAIL %s: got ov=%b ctrl=%h data=%h ir=%b occ=%0d, want ov=%b ctrl=%h data=%h ir=%b occ=%0d",
                     name, out_valid, out_ctrl, out_data, in_ready, occupancy, ov, c, d, ir, occ);
        end
    endtask

    task automatic add(input string n, input logic f, input logic v, input logic [7:0] c,
                       input logic [95:0] d, input logic r, input logic eov,
                       input logic [7:0] ec, input logic [95:0] ed, input logic eir,
                       input logic [1:0] eocc);
        vec_t x;
        x.name = n; x.flush = f; x.vld = v; x.ctrl = c; x.data = d; x.rdy = r;
        x.e_ov = eov; x.e_ctrl = ec; x.e_data = ed; x.e_ir = eir; x.e_occ = eocc;
        vt.push_back(x);
    endtask

    initial begin
        //   name          fl v  ctrl   data       rdy  ov ctrl   data      ir occ
        add("stream1",     0, 1, 8'h11, 96'h1,     1,   1, 8'h11, 96'h1,    1, 1);
        add("stream2",     0, 1, 8'h22, 96'h2,     1,   1, 8'h22, 96'h2,    1, 1);
        add("stream3",     0, 1, 8'h33, 96'h3,     1,   1, 8'h33, 96'h3,    1, 1);
        add("drain3",      0, 0, 8'h00, 96'h0,     1,   0, 8'h00, 96'h3,    1, 0);
        add("bp_loadA",    0, 1, 8'hAA, 96'hA,     1,   1, 8'hAA, 96'hA,    1, 1);
        add("bp_skidB",    0, 1, 8'hBB, 96'hB,     0,   1, 8'hAA, 96'hA,    0, 2);
        add("bp_holdC",    0, 1, 8'hCC, 96'hC,     0,   1, 8'hAA, 96'hA,    0, 2);
        add("bp_outB",     0, 1, 8'hCC, 96'hC,     1,   1, 8'hBB, 96'hB,    1, 1);
        add("bp_outC",     0, 1, 8'hCC, 96'hC,     1,   1, 8'hCC, 96'hC,    1, 1);
        add("bp_empty",    0, 0, 8'h00, 96'h0,     1,   0, 8'h00, 96'hC,    1, 0);
        add("fl_load4",    0, 1, 8'h44, 96'h4,     1,   1, 8'h44, 96'h4,    1, 1);
        add("fl_skid5",    0, 1, 8'h55, 96'h5,     0,   1, 8'h44, 96'h4,    0, 2);
        add("fl_killD",    1, 1, 8'h66, 96'h6,     0,   0, 8'h00, 96'h0,    1, 0);
        add("idle_junk",   0, 0, 8'hEE, 96'hDEAD,  0,   0, 8'h00, 96'h0,    1, 0);
        add("bub_FF",      0, 1, 8'hFF, 96'hF0,    1,   1, 8'hFF, 96'hF0,   1, 1);
        add("bub_gate",    0, 0, 8'h00, 96'h0,     1,   0, 8'h00, 96'hF0,   1, 0);
        add("fl_empty",    1, 1, 8'h77, 96'h7,     1,   0, 8'h00, 96'h0,    1, 0);
        add("st_load8",    0, 1, 8'h88, 96'h8,     0,   1, 8'h88, 96'h8,    1, 1);
        add("st_hold8",    0, 0, 8'h00, 96'h0,     0,   1, 8'h88, 96'h8,    1, 1);
        add("st_out8",     0, 0, 8'h00, 96'h0,     1,   0, 8'h00, 96'h8,    1, 0);

        // reset held while clock toggles and input is offered
        in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 96'h123; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("reset_hold", 0, 8'h00, 96'h0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset_release", 0, 8'h00, 96'h0, 1, 0);
        in_valid = 1'b0;

        foreach (vt[i]) begin
            flush = vt[i].flush; in_valid = vt[i].vld; in_ctrl = vt[i].ctrl;
            in_data = vt[i].data; out_ready = vt[i].rdy;
            @(posedge clk);
            #1 check(vt[i].name, vt[i].e_ov, vt[i].e_ctrl, vt[i].e_data, vt[i].e_ir, vt[i].e_occ);
        end
        flush = 1'b0;

        // simultaneous drain and fill
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_ctrl = 8'(k + 1); in_data = 96'(k + 100);
            @(posedge clk);
            #1 check($sformatf("flow%0d", k), 1, 8'(k + 1), 96'(k + 100), 1, 1);
        end

        // async reset with two entries buffered
        in_ctrl = 8'h99; in_data = 96'h99; out_ready = 1'b0;
        @(posedge clk);
        #1 check("pre_rst_full", 1, 8'h0A, 96'd109, 0, 2);
        #3 rst_n = 1'b0;
        #1 check("async_rst", 0, 8'h00, 96'h0, 1, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_ctrl = 8'h31; in_data = 96'h31; out_ready = 1'b1;
        @(posedge clk);
        #1 check("post_rst_load", 1, 8'h31, 96'h31, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
